// File: rtl/assist_pkg.sv
// Shared types and saturating arithmetic helpers for the assistance controller.
package assist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        BRAKE = 2'd2,
        FAULT = 2'd3
    } state_t;

    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value, input int width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 1));
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

    // The most negative code has no positive twin, so it maps to the largest magnitude.
    function automatic logic signed [31:0] abs_sat(input logic signed [31:0] value, input int width);
        logic signed [31:0] lo;
        lo = -(32'sd1 <<< (width - 1));
        if (value <= lo) return -(lo + 32'sd1);
        return (value < 0) ? -value : value;
    endfunction

endpackage

// File: rtl/assist_slew_limiter.sv
// Rate limiter: moves the command toward its target by a bounded step once per prescaler period.
module assist_slew_limiter #(
    parameter int OUT_W       = 10,
    parameter int SLEW_PERIOD = 1000,
    parameter int SLEW_STEP   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OUT_W-1:0] target,
    input  logic             force_zero,
    output logic [OUT_W-1:0] assist
);

    localparam int PW = $clog2(SLEW_PERIOD + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SLEW_PERIOD - 1);
    localparam logic [OUT_W-1:0] STEP = OUT_W'(SLEW_STEP);

    logic [PW-1:0]    presc;
    logic [OUT_W-1:0] diff;
    logic [OUT_W-1:0] step_v;
    logic             wrap;

    always_comb begin
        diff   = (target > assist) ? (target - assist) : (assist - target);
        step_v = (diff > STEP) ? STEP : diff;
        wrap   = (presc == PRESC_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc  <= '0;
            assist <= '0;
        end else begin
            presc <= wrap ? '0 : presc + 1'b1;
            if (force_zero)
                assist <= '0;
            else if (wrap)
                assist <= (target > assist) ? (assist + step_v) : (assist - step_v);
        end
    end

endmodule

// File: rtl/assistance_pi_controller.sv
// Heart-rate PI assistance controller: tilt/brake/cadence supervision FSM, cadence
// watchdog and a two-stage PI pipeline feeding a slew-limited motor command.
//
//  state | meaning
//  IDLE  | no assistance requested; target 0, output slews down
//  RUN   | pedalling and enabled; PI loop drives target
//  BRAKE | brake lever held; output and target forced to 0, integrator held
//  FAULT | excessive tilt; output, target and integrator cleared
module assistance_pi_controller
    import assist_pkg::*;
#(
    parameter int HR_W        = 8,
    parameter int ANGLE_W     = 10,
    parameter int OUT_W       = 10,
    parameter int INT_W       = 16,
    parameter int KP          = 4,
    parameter int KI          = 1,
    parameter int GAIN_SHIFT  = 2,
    parameter int TILT_LIMIT  = 45,
    parameter int TILT_HYST   = 5,
    parameter int CAD_TIMEOUT = 50000000,
    parameter int SLEW_PERIOD = 1000,
    parameter int SLEW_STEP   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic signed [ANGLE_W-1:0] roll,
    input  logic signed [ANGLE_W-1:0] pitch,
    input  logic [HR_W-1:0]           heart_rate,
    input  logic [HR_W-1:0]           hr_setpoint,
    input  logic                      hr_valid,
    input  logic                      cadence,
    input  logic                      brake,
    input  logic                      enable,
    output logic signed [OUT_W-1:0]   assist_out,
    output logic                      fault,
    output logic [1:0]                state
);

    localparam int CAD_W = $clog2(CAD_TIMEOUT + 1);
    localparam logic [CAD_W-1:0] CAD_RELOAD = CAD_W'(CAD_TIMEOUT);
    localparam logic signed [31:0] UMAX = (32'sd1 <<< (OUT_W - 1)) - 32'sd1;
    localparam logic [OUT_W-1:0] TMAX = {1'b0, {(OUT_W-1){1'b1}}};

    state_t                  state_q, state_d;
    logic                    cad_s1, cad_s2, cad_s3;
    logic [CAD_W-1:0]        cad_timer;
    logic                    pedalling, tilt_over, tilt_clear;
    logic                    accept, force_zero, windup, p1;
    logic signed [31:0]      err, icand, u1, u2;
    logic signed [INT_W-1:0] integ, icand_q;
    logic signed [HR_W:0]    err_q;
    logic [OUT_W-1:0]        target, assist_u;

    function automatic logic signed [31:0] pi_u(input logic signed [31:0] e, input logic signed [31:0] i);
        return (KP * e + KI * i) >>> GAIN_SHIFT;
    endfunction

    always_comb begin
        pedalling  = (cad_timer != '0);
        tilt_over  = (abs_sat(32'(roll), ANGLE_W) > TILT_LIMIT) ||
                     (abs_sat(32'(pitch), ANGLE_W) > TILT_LIMIT);
        tilt_clear = (abs_sat(32'(roll), ANGLE_W) < TILT_LIMIT - TILT_HYST) &&
                     (abs_sat(32'(pitch), ANGLE_W) < TILT_LIMIT - TILT_HYST);
        state_d = state_q;
        if (tilt_over) begin
            state_d = FAULT;
        end else begin
            case (state_q)
                FAULT:   if (tilt_clear) state_d = IDLE;
                BRAKE:   if (!brake) state_d = IDLE;
                IDLE:    if (brake) state_d = BRAKE;
                         else if (enable && pedalling) state_d = RUN;
                RUN:     if (brake) state_d = BRAKE;
                         else if (!enable || !pedalling) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        force_zero = (state_d == FAULT) || (state_d == BRAKE);
        // A sample is only taken if the loop stays in RUN across this edge.
        accept = hr_valid && (state_q == RUN) && (state_d == RUN) && (heart_rate != '0);
        err    = 32'($signed({1'b0, hr_setpoint})) - 32'($signed({1'b0, heart_rate}));
        icand  = sat_signed(32'(integ) + err, INT_W);
        u1     = pi_u(err, icand);
        windup = ((u1 > UMAX) && (err > 0)) || ((u1 < 0) && (err < 0));
        u2     = pi_u(32'(err_q), 32'(icand_q));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            fault   <= 1'b0;
        end else begin
            state_q <= state_d;
            fault   <= (state_d == FAULT);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cad_s1    <= 1'b0;
            cad_s2    <= 1'b0;
            cad_s3    <= 1'b0;
            cad_timer <= '0;
        end else begin
            cad_s1 <= cadence;
            cad_s2 <= cad_s1;
            cad_s3 <= cad_s2;
            if (cad_s2 && !cad_s3)
                cad_timer <= CAD_RELOAD;
            else if (cad_timer != '0)
                cad_timer <= cad_timer - 1'b1;
        end
    end

    // Stage 1 latches error and candidate integrator; stage 2 turns them into a target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            integ   <= '0;
            icand_q <= '0;
            err_q   <= '0;
            p1      <= 1'b0;
            target  <= '0;
        end else if (state_d == FAULT) begin
            integ  <= '0;
            p1     <= 1'b0;
            target <= '0;
        end else if (state_d != RUN) begin
            p1     <= 1'b0;
            target <= '0;
        end else begin
            p1 <= accept;
            if (accept) begin
                err_q   <= err[HR_W:0];
                icand_q <= icand[INT_W-1:0];
                if (!windup) integ <= icand[INT_W-1:0];
            end
            if (p1)
                target <= (u2 < 0) ? '0 : (u2 > UMAX) ? TMAX : u2[OUT_W-1:0];
        end
    end

    assist_slew_limiter #(
        .OUT_W       (OUT_W),
        .SLEW_PERIOD (SLEW_PERIOD),
        .SLEW_STEP   (SLEW_STEP)
    ) u_slew (
        .clk        (clk),
        .rst_n      (rst_n),
        .target     (target),
        .force_zero (force_zero),
        .assist     (assist_u)
    );

    assign assist_out = $signed(assist_u);
    assign state      = state_q;

endmodule
